// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Width needed to hold an occupancy value 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         w_idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         r_idx_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[w_idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[r_idx_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: arbitrary depth, STD/FWFT read, level flags,
// synchronous flush and overflow/underflow pulses.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    localparam int unsigned CW        = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Reject illegal threshold settings at elaboration.
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("fifo_param: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_param: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [AW-1:0]         w_idx_q, w_idx_d;
    logic [AW-1:0]         r_idx_q, r_idx_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc_c, wr_acc_c;
    logic [DATA_WIDTH-1:0] mem_rdata;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en_i (wr_acc_c),
        .w_idx_i (w_idx_q),
        .wdata_i (data_in),
        .r_idx_i (r_idx_q),
        .rdata_o (mem_rdata)
    );

    // Acceptance, index/count update and error detection; flush overrides all.
    always_comb begin
        rd_acc_c    = rd_en && (count_q != '0) && !flush;
        wr_acc_c    = wr_en && ((count_q != CW'(DEPTH)) || rd_acc_c) && !flush;
        w_idx_d     = w_idx_q;
        r_idx_d     = r_idx_q;
        count_d     = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
        overflow_d  = wr_en && !wr_acc_c && !flush;
        underflow_d = rd_en && !rd_acc_c && !flush;
        if (wr_acc_c) begin
            w_idx_d = (w_idx_q == AW'(DEPTH - 1)) ? '0 : w_idx_q + AW'(1);
        end
        if (rd_acc_c) begin
            r_idx_d = (r_idx_q == AW'(DEPTH - 1)) ? '0 : r_idx_q + AW'(1);
        end
        if (flush) begin
            w_idx_d = '0;
            r_idx_d = '0;
            count_d = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_idx_q     <= '0;
            r_idx_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_idx_q     <= w_idx_d;
            r_idx_q     <= r_idx_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly whenever the FIFO holds data.
        assign data_out = (count_q != '0) ? mem_rdata : '0;
        assign rd_valid = (count_q != '0);
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  rd_valid_q, rd_valid_d;

        // Registered read: capture the head word on each accepted pop.
        always_comb begin
            data_d     = data_q;
            rd_valid_d = rd_acc_c;
            if (flush) begin
                data_d = '0;
            end else if (rd_acc_c) begin
                data_d = mem_rdata;
            end
        end

        // Read output registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                data_q     <= data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign data_out = data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a standard-read and an FWFT instance, DEPTH=5.
module tb_fifo_param;

    logic       clk;
    logic       rst;

    logic       a_flush, a_wr_en, a_rd_en;
    logic [7:0] a_data_in, a_data_out;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_count;

    logic       f_flush, f_wr_en, f_rd_en;
    logic [7:0] f_data_in, f_data_out;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [2:0] f_count;

    int errors = 0;
    int checks = 0;

    fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_std (
        .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr_en), .data_in(a_data_in),
        .rd_en(a_rd_en), .data_out(a_data_out), .rd_valid(a_rd_valid), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .data_in(f_data_in),
        .rd_en(f_rd_en), .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_data_in = 8'h00;
        f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_data_in = 8'h00;
        #1 rst = 1'b0;
        #2;
        check("rst_count", a_count, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_ae", a_ae, 1);
        check("rst_af", a_af, 0);
        check("rst_rdv", a_rd_valid, 0);
        check("rst_dout", a_data_out, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_udf", a_udf, 0);
        check("rst_f_rdv", f_rd_valid, 0);
        check("rst_f_dout", f_data_out, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: fill, overflow, drain
        for (int i = 0; i < 5; i++) begin
            a_wr_en = 1; a_data_in = 8'(8'h11 + i);
            step();
            check("t1_count", a_count, i + 1);
            check("t1_af", a_af, (i + 1 >= 4) ? 1 : 0);
            check("t1_full", a_full, (i + 1 == 5) ? 1 : 0);
            check("t1_ae", a_ae, (i + 1 <= 1) ? 1 : 0);
        end
        a_data_in = 8'h16;
        step();
        check("t1_ovf", a_ovf, 1);
        check("t1_ovf_count", a_count, 5);
        a_wr_en = 0;
        step();
        check("t1_ovf_pulse", a_ovf, 0);
        for (int i = 0; i < 5; i++) begin
            a_rd_en = 1;
            step();
            check("t1_rd_data", a_data_out, 8'h11 + i);
            check("t1_rd_valid", a_rd_valid, 1);
            check("t1_rd_count", a_count, 4 - i);
        end
        a_rd_en = 0;
        step();
        check("t1_rdv_drop", a_rd_valid, 0);
        check("t1_hold", a_data_out, 8'h15);
        check("t1_empty", a_empty, 1);

        // 2: stream 20 values, indices wrap several times
        for (int k = 0; k <= 20; k++) begin
            a_wr_en = (k < 20); a_data_in = 8'(8'h80 + k);
            a_rd_en = (k > 0);
            step();
            if (k > 0) begin
                check("t2_data", a_data_out, 8'h80 + k - 1);
                check("t2_valid", a_rd_valid, 1);
            end
        end
        a_wr_en = 0; a_rd_en = 0;
        check("t2_count", a_count, 0);

        // 3: full with simultaneous read and write
        for (int i = 0; i < 5; i++) begin
            a_wr_en = 1; a_data_in = 8'(8'h21 + i);
            step();
        end
        a_rd_en = 1; a_data_in = 8'hAA;
        step();
        check("t3_count", a_count, 5);
        check("t3_ovf", a_ovf, 0);
        check("t3_data", a_data_out, 8'h21);
        a_wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_drain", a_data_out, (i == 4) ? 8'hAA : 8'h22 + i);
        end
        a_rd_en = 0;
        step();
        check("t3_empty", a_empty, 1);

        // 4: empty with simultaneous read and write
        a_wr_en = 1; a_rd_en = 1; a_data_in = 8'h3C;
        step();
        check("t4_udf", a_udf, 1);
        check("t4_count", a_count, 1);
        check("t4_rdv", a_rd_valid, 0);
        a_wr_en = 0;
        step();
        check("t4_data", a_data_out, 8'h3C);
        check("t4_valid", a_rd_valid, 1);
        check("t4_udf_pulse", a_udf, 0);
        a_rd_en = 0;

        // 5: FWFT presentation
        f_wr_en = 1; f_data_in = 8'h42;
        step();
        f_wr_en = 0;
        check("t5_data", f_data_out, 8'h42);
        check("t5_valid", f_rd_valid, 1);
        check("t5_count", f_count, 1);
        f_rd_en = 1;
        step();
        f_rd_en = 0;
        check("t5_empty", f_empty, 1);
        check("t5_zero", f_data_out, 0);
        check("t5_novalid", f_rd_valid, 0);
        f_wr_en = 1; f_data_in = 8'h01;
        step();
        f_data_in = 8'h02;
        step();
        f_wr_en = 0;
        check("t5_head1", f_data_out, 8'h01);
        f_rd_en = 1;
        step();
        f_rd_en = 0;
        check("t5_head2", f_data_out, 8'h02);
        check("t5_count2", f_count, 1);

        // 6: flush with concurrent write, then asynchronous reset mid-write
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1; a_data_in = 8'(8'h51 + i);
            step();
        end
        a_flush = 1; a_data_in = 8'h99;
        step();
        a_flush = 0; a_wr_en = 0;
        check("t6_count", a_count, 0);
        check("t6_empty", a_empty, 1);
        check("t6_ovf", a_ovf, 0);
        check("t6_rdv", a_rd_valid, 0);
        check("t6_dout", a_data_out, 0);
        a_rd_en = 1;
        step();
        a_rd_en = 0;
        check("t6_flushed_udf", a_udf, 1);
        a_wr_en = 1; a_data_in = 8'h61;
        step();
        a_data_in = 8'h62;
        step();
        a_wr_en = 0; a_rd_en = 1;
        step();
        check("t6_pre_data", a_data_out, 8'h61);
        a_rd_en = 0; a_wr_en = 1; a_data_in = 8'h63;
        #2 rst = 1'b0;
        #1;
        check("t6_rst_count", a_count, 0);
        check("t6_rst_empty", a_empty, 1);
        check("t6_rst_ae", a_ae, 1);
        check("t6_rst_dout", a_data_out, 0);
        check("t6_rst_rdv", a_rd_valid, 0);
        check("t6_rst_f_count", f_count, 0);
        a_wr_en = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        check("t6_post_count", a_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
